// File: rtl/his_equ_map_if.sv
// Pixel stream, histogram beat stream and remapped pixel stream of the
// histogram-equalization mapper, bundled as one port group.
interface his_equ_map_if;
    logic        img_vsync;
    logic        img_href;
    logic [7:0]  img_gray;
    logic [7:0]  pixel_level;
    logic [19:0] pixel_level_acc_num;
    logic        pixel_level_valid;
    logic        post_vsync;
    logic        post_href;
    logic [7:0]  post_gray;
    logic        lut_ready;
    logic        lut_err;

    modport master (
        output img_vsync, img_href, img_gray,
        output pixel_level, pixel_level_acc_num, pixel_level_valid,
        input  post_vsync, post_href, post_gray, lut_ready, lut_err
    );

    modport slave (
        input  img_vsync, img_href, img_gray,
        input  pixel_level, pixel_level_acc_num, pixel_level_valid,
        output post_vsync, post_href, post_gray, lut_ready, lut_err
    );
endinterface

// File: rtl/his_equ_map.sv
// Builds a 256x8 equalization LUT from the cumulative histogram stream and
// remaps later frames through it; the LUT is ping-pong buffered per frame.
module his_equ_map #(
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int SHIFT      = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    his_equ_map_if.slave bus
);
    localparam logic [63:0] NPIX   = 64'(IMG_WIDTH) * 64'(IMG_HEIGHT);
    localparam logic [63:0] MULT64 = ((64'd255 << SHIFT) + NPIX / 64'd2) / NPIX;
    localparam logic [31:0] MULT   = MULT64[31:0];
    localparam logic [52:0] HALF   = 53'd1 << (SHIFT - 1);

    typedef enum logic {IDLE, LOAD} state_t;

    state_t      state, state_nxt;
    logic [7:0]  exp_lvl, exp_nxt;
    logic        accept, start, last, err;

    logic        s1_vld, s1_last;
    logic [7:0]  s1_level;
    logic [51:0] s1_prod;
    logic [52:0] rnd, scaled;
    logic [7:0]  map;

    logic        wr_bank, rd_bank, pending, ready, err_q, swap, vs_rise;
    logic [1:0]  vsync_d, href_d;
    logic [7:0]  gray_d1, gray_d2, lut_q;
    logic        ready_d;
    logic [7:0]  lut [512];

    // Level 0 always (re)starts a load; anything out of sequence aborts it.
    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_lvl;
        accept    = 1'b0;
        start     = 1'b0;
        last      = 1'b0;
        err       = 1'b0;
        if (bus.pixel_level_valid) begin
            if (bus.pixel_level == 8'd0) begin
                accept    = 1'b1;
                start     = 1'b1;
                exp_nxt   = 8'd1;
                state_nxt = LOAD;
            end else if (state == LOAD && bus.pixel_level == exp_lvl) begin
                accept  = 1'b1;
                exp_nxt = exp_lvl + 8'd1;
                if (bus.pixel_level == 8'd255) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end else begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            exp_lvl  <= 8'd0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s1_level <= 8'd0;
            s1_prod  <= 52'd0;
        end else begin
            state    <= state_nxt;
            exp_lvl  <= exp_nxt;
            s1_vld   <= accept;
            s1_last  <= last;
            s1_level <= bus.pixel_level;
            s1_prod  <= {32'd0, bus.pixel_level_acc_num} * {20'd0, MULT};
        end
    end

    always_comb begin
        rnd    = {1'b0, s1_prod} + HALF;
        scaled = rnd >> SHIFT;
        map    = (|scaled[52:8]) ? 8'hFF : scaled[7:0];
    end

    // Swap only when no load is in flight, so a bank never flips under a write.
    assign vs_rise = bus.img_vsync & ~vsync_d[0];
    assign swap    = vs_rise && pending && state == IDLE && !s1_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            pending <= 1'b0;
            ready   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= err;
            if (swap) begin
                rd_bank <= wr_bank;
                wr_bank <= ~wr_bank;
                ready   <= 1'b1;
                pending <= 1'b0;
            end
            if (s1_vld && s1_last) pending <= 1'b1;
            // A restarted load overwrites the pending table in place.
            if (start) pending <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_d <= 2'b00;
            href_d  <= 2'b00;
            gray_d1 <= 8'd0;
            gray_d2 <= 8'd0;
            ready_d <= 1'b0;
        end else begin
            vsync_d <= {vsync_d[0], bus.img_vsync};
            href_d  <= {href_d[0], bus.img_href};
            gray_d1 <= bus.img_gray;
            gray_d2 <= gray_d1;
            ready_d <= ready;
        end
    end

    always_ff @(posedge clk) begin
        if (s1_vld) lut[{wr_bank, s1_level}] <= map;
        lut_q <= lut[{rd_bank, gray_d1}];
    end

    assign bus.post_vsync = vsync_d[1];
    assign bus.post_href  = href_d[1];
    assign bus.post_gray  = !href_d[1] ? 8'd0 : (ready_d ? lut_q : gray_d2);
    assign bus.lut_ready  = ready;
    assign bus.lut_err    = err_q;
endmodule
